// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: assembles RV32I lw/sw/R-type/beq words from instruction
// fields and writes them sequentially into instruction memory through a
// registered write port.
// Optional feature macro: ENC_IMM_CHECK_EN enables the sticky immediate-range
// error flag. Without it, immediates are silently truncated and err is tied low.
module instr_encoder_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        cls,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [12:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        xfer;
  logic        last_slot;
  logic [31:0] enc_word;

  // A start pulse also blocks acceptance so a restart never consumes a word.
  assign in_ready  = (state_q == RUN) && !clr && !start && (count < DEPTH_C);
  assign xfer      = in_valid && in_ready;
  assign last_slot = (count == DEPTH_C - 1'b1);
  assign done      = (state_q == FULL);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clr beats start, start beats a transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!clr && start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (clr) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end else if (xfer && last_slot) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (clr) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Field-to-word encoder; unused fields for a class are simply not selected.
  always_comb begin
    enc_word = 32'h0;
    case (cls)
      2'b00: enc_word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      2'b01: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      2'b10: enc_word = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OP_RTYPE};
      2'b11: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
      default: enc_word = 32'h0;
    endcase
  end

  // Write port and counter: one registered write per accepted transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      count      <= '0;
    end else begin
      if (clr || start) begin
        count <= '0;
      end else if (xfer) begin
        count <= count + 1'b1;
      end
      if (xfer) begin
        imem_we    <= 1'b1;
        imem_addr  <= count[ADDR_W-1:0];
        imem_wdata <= enc_word;
      end else begin
        imem_we    <= 1'b0;
      end
    end
  end

`ifdef ENC_IMM_CHECK_EN
  logic imm_bad;
  logic err_q;

  // Loads/stores must be 12-bit sign-representable; branch offsets must be even.
  always_comb begin
    imm_bad = 1'b0;
    case (cls)
      2'b00, 2'b01: imm_bad = (imm[12] != imm[11]);
      2'b11:        imm_bad = imm[0];
      default:      imm_bad = 1'b0;
    endcase
  end

  // Sticky error flag, cleared only by reset, start or clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (clr || start) begin
      err_q <= 1'b0;
    end else if (xfer && imm_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_imm0;
  assign unused_imm0 = imm[0];
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (DEPTH=4 to reach FULL quickly).
module tb_instr_encoder_loader;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

`ifdef ENC_IMM_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        cls;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic [12:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              err;

  typedef struct {
    logic [1:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [12:0] imm;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
  } exp_t;

  vec_t vecs[7];
  vec_t none;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   mstate = 0;
  int   mcount = 0;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .cls(cls), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .done(done), .err(err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    if (reset === 1'b0 && imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", {29'h0, imem_addr}, 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("write_addr", {29'h0, imem_addr}, {29'h0, e.addr});
        checkOutput("write_data", imem_wdata, e.word);
      end
    end
  end

  // Drive one cycle of inputs, predict acceptance, then check after the edge.
  task automatic applyStimulus(input logic s, input logic c, input logic v, input vec_t vv);
    logic exp_rdy;
    logic xf;
    start = s; clr = c; in_valid = v;
    cls = vv.cls; rd = vv.rd; rs1 = vv.rs1; rs2 = vv.rs2;
    funct3 = vv.f3; funct7b5 = vv.f7b5; imm = vv.imm;
    #1;
    exp_rdy = (mstate == 1) && !c && !s && (mcount < DEPTH);
    checkOutput("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
    xf = v && exp_rdy;
    if (xf) begin
      exp_t e;
      e.addr = mcount[ADDR_W-1:0];
      e.word = vv.word;
      sb.push_back(e);
    end
    if (c) begin
      mstate = 0; mcount = 0;
    end else if (s) begin
      mstate = 1; mcount = 0;
    end else if (xf) begin
      mcount++;
      if (mcount == DEPTH) mstate = 2;
    end
    @(posedge clk);
    #1;
    checkOutput("imem_we", {31'h0, imem_we}, {31'h0, xf});
    checkOutput("count", {28'h0, count}, mcount);
    checkOutput("done", {31'h0, done}, {31'h0, (mstate == 2)});
    start = 1'b0; clr = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 1'b0, 13'd8,     32'h00812283};
    vecs[1] = '{2'b01, 5'd0, 5'd2, 5'd6, 3'b010, 1'b0, 13'd12,    32'h00612623};
    vecs[2] = '{2'b10, 5'd7, 5'd5, 5'd6, 3'b000, 1'b0, 13'd0,     32'h006283B3};
    vecs[3] = '{2'b11, 5'd0, 5'd5, 5'd6, 3'b000, 1'b0, 13'h1FF8,  32'hFE628CE3};
    vecs[4] = '{2'b10, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 13'd0,     32'h403100B3};
    vecs[5] = '{2'b00, 5'd1, 5'd2, 5'd0, 3'b010, 1'b0, 13'h1FFC,  32'hFFC12083};
    vecs[6] = '{2'b11, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 13'h0003,  32'h00000163};
    none    = '{2'b00, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 13'd0,     32'h0};

    reset = 1'b1; start = 1'b0; clr = 1'b0; in_valid = 1'b0;
    cls = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7b5 = 1'b0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_we", {31'h0, imem_we}, 32'h0);
    checkOutput("rst_addr", {29'h0, imem_addr}, 32'h0);
    checkOutput("rst_wdata", imem_wdata, 32'h0);
    checkOutput("rst_count", {28'h0, count}, 32'h0);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_err", {31'h0, err}, 32'h0);
    checkOutput("rst_ready", {31'h0, in_ready}, 32'h0);
    reset = 1'b0;

    // Fill to DEPTH with six back-to-back requests; only four are accepted.
    applyStimulus(1'b1, 1'b0, 1'b0, none);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, vecs[i]);

    // Restart from FULL, then transfers with a gap; wdata holds during the gap.
    applyStimulus(1'b1, 1'b0, 1'b0, none);
    applyStimulus(1'b0, 1'b0, 1'b1, vecs[4]);
    applyStimulus(1'b0, 1'b0, 1'b0, none);
    checkOutput("wdata_hold", imem_wdata, vecs[4].word);
    applyStimulus(1'b0, 1'b0, 1'b1, vecs[5]);

    // clr with in_valid: no write, back to IDLE, no acceptance afterwards.
    applyStimulus(1'b0, 1'b1, 1'b1, vecs[0]);
    applyStimulus(1'b0, 1'b0, 1'b1, vecs[1]);

    // start while RUN with in_valid: counter cleared and nothing accepted.
    applyStimulus(1'b1, 1'b0, 1'b0, none);
    applyStimulus(1'b0, 1'b0, 1'b1, vecs[0]);
    applyStimulus(1'b1, 1'b0, 1'b1, vecs[2]);
    applyStimulus(1'b0, 1'b0, 1'b1, vecs[1]);

    // Odd branch offset: word still written, err sticky until start.
    applyStimulus(1'b0, 1'b0, 1'b1, vecs[6]);
    checkOutput("err_set", {31'h0, err}, {31'h0, ERR_EXP});
    applyStimulus(1'b0, 1'b0, 1'b0, none);
    checkOutput("err_sticky", {31'h0, err}, {31'h0, ERR_EXP});
    applyStimulus(1'b1, 1'b0, 1'b0, none);
    checkOutput("err_clear", {31'h0, err}, 32'h0);

    // Asynchronous reset in the middle of a write cycle drops the strobe at once.
    applyStimulus(1'b0, 1'b0, 1'b1, vecs[2]);
    sb.delete();
    reset = 1'b1;
    #1;
    checkOutput("async_rst_we", {31'h0, imem_we}, 32'h0);
    checkOutput("async_rst_count", {28'h0, count}, 32'h0);
    mstate = 0; mcount = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, vecs[0]);
    repeat (2) @(posedge clk);
    checkOutput("sb_drained", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
